// File: rtl/draw_ctrl_pkg.sv
// Shared constants and state encoding for the CHIP-8 draw controller.
package draw_ctrl_pkg;

    localparam logic [15:0] OP_CLS      = 16'h00E0;
    localparam logic [3:0]  OP_DRAW_NIB = 4'hD;
    localparam logic [3:0]  REG_VF      = 4'hF;

    localparam int SCR_X_W = 6;
    localparam int SCR_Y_W = 5;

    localparam int CLS_CYCLES_DEFAULT  = 2048;
    localparam int START_GUARD_DEFAULT = 3;

    // Wide enough for the clear wait and the post-request guard.
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_X,
        ST_RD_Y,
        ST_CAP_Y,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_WB,
        ST_CLS_ISSUE,
        ST_CLS_WAIT,
        ST_FIN
    } state_e;

    // True for any DXYN sprite-draw instruction.
    function automatic logic isDrawOp(input logic [15:0] op);
        return op[15:12] == OP_DRAW_NIB;
    endfunction

endpackage

// File: rtl/draw_ctrl.sv
// CPU-side initiator for the sprite-draw engine: runs CLS (00E0) and DXYN,
// fetching Vx/Vy, requesting the engine and writing the collision flag to VF.
module draw_ctrl
    import draw_ctrl_pkg::*;
#(
    parameter int CLS_CYCLES  = CLS_CYCLES_DEFAULT,
    parameter int START_GUARD = START_GUARD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opcode,
    input  logic [15:0] I,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [3:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        draw_en,
    output logic        draw_cls_en,
    output logic [15:0] draw_I,
    output logic [10:0] draw_start_pix,
    output logic [3:0]  draw_nibbles,
    input  logic        draw_busy,
    input  logic        draw_col
);

    state_e               state_q, state_d;
    logic [15:0]          opcode_q, opcode_d;
    logic [15:0]          iReg_q, iReg_d;
    logic [SCR_X_W-1:0]   x_q, x_d;
    logic [SCR_Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 colAcc_q, colAcc_d;
    logic [15:0]          drawI_q, drawI_d;
    logic [10:0]          drawPix_q, drawPix_d;
    logic [3:0]           drawNib_q, drawNib_d;
    logic                 isIllegal;
    logic                 unusedRdataBits;

    // Coordinates wrap by truncation, so the top bits of Vx/Vy are dropped.
    assign unusedRdataBits = ^rf_rdata[7:6];

    assign isIllegal = !((opcode_q == OP_CLS) || isDrawOp(opcode_q));

    // The engine sees fresh request fields during the en pulse and held copies afterwards.
    assign draw_I         = draw_en ? iReg_q          : drawI_q;
    assign draw_start_pix = draw_en ? {y_q, x_q}      : drawPix_q;
    assign draw_nibbles   = draw_en ? opcode_q[3:0]   : drawNib_q;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            iReg_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            colAcc_q  <= 1'b0;
            drawI_q   <= '0;
            drawPix_q <= '0;
            drawNib_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            iReg_q    <= iReg_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            colAcc_q  <= colAcc_d;
            drawI_q   <= drawI_d;
            drawPix_q <= drawPix_d;
            drawNib_q <= drawNib_d;
        end
    end

    // Next-state sequencing, handshakes and register-file/engine strobes.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        iReg_d      = iReg_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        colAcc_d    = colAcc_q;
        drawI_d     = drawI_q;
        drawPix_d   = drawPix_q;
        drawNib_d   = drawNib_q;
        done        = 1'b0;
        busy        = 1'b1;
        err         = 1'b0;
        rf_raddr    = 4'h0;
        rf_we       = 1'b0;
        rf_waddr    = 4'h0;
        rf_wdata    = 8'h00;
        draw_en     = 1'b0;
        draw_cls_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = start;
                if (start) begin
                    opcode_d = opcode;
                    iReg_d   = I;
                    if (opcode == OP_CLS) begin
                        state_d = ST_CLS_ISSUE;
                    end else if (isDrawOp(opcode)) begin
                        state_d = ST_RD_X;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD_X: begin
                rf_raddr = opcode_q[11:8];
                state_d  = ST_RD_Y;
            end
            ST_RD_Y: begin
                rf_raddr = opcode_q[7:4];
                x_d      = rf_rdata[SCR_X_W-1:0];
                state_d  = ST_CAP_Y;
            end
            ST_CAP_Y: begin
                y_d = rf_rdata[SCR_Y_W-1:0];
                if (opcode_q[3:0] == 4'h0) begin
                    colAcc_d = 1'b0;
                    state_d  = ST_WB;
                end else begin
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!draw_busy) begin
                    draw_en   = 1'b1;
                    drawI_d   = iReg_q;
                    drawPix_d = {y_q, x_q};
                    drawNib_d = opcode_q[3:0];
                    colAcc_d  = 1'b0;
                    cnt_d     = CNT_W'(START_GUARD - 1);
                    state_d   = ST_GUARD;
                end
            end
            ST_GUARD: begin
                colAcc_d = colAcc_q | draw_col;
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                colAcc_d = colAcc_q | draw_col;
                if (!draw_busy) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = REG_VF;
                rf_wdata = {7'b0, colAcc_q};
                state_d  = ST_FIN;
            end
            ST_CLS_ISSUE: begin
                if (!draw_busy) begin
                    draw_cls_en = 1'b1;
                    cnt_d       = CNT_W'(CLS_CYCLES - 1);
                    state_d     = ST_CLS_WAIT;
                end
            end
            ST_CLS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                busy    = 1'b0;
                err     = isIllegal;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_draw_ctrl.sv
// Scoreboard bench for draw_ctrl with a register-file model and a scripted
// draw-engine model; expected events are derived from the opcode rules.
module tb_draw_ctrl;

   localparam int CLS = 2048;

   typedef struct {
      int kind;   // 0 draw_en, 1 draw_cls_en, 2 rf_we, 3 done
      int cyc;
      int a;
      int b;
      int c;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] opcode = 16'h0;
   logic [15:0] I = 16'h0;
   logic        done, busy, err;
   logic [3:0]  rf_raddr;
   logic [7:0]  rf_rdata = 8'h00;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic        draw_en, draw_cls_en;
   logic [15:0] draw_I;
   logic [10:0] draw_start_pix;
   logic [3:0]  draw_nibbles;
   logic        draw_busy = 1'b0;
   logic        draw_col = 1'b0;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   ev_t expQ[$];
   logic [7:0] rf [16];

   int vsyncFrom = 1, vsyncTo = 0;
   int engFrom = 1, engTo = 0, colAt = -1;
   int engLen = 1, colOff = -1;

   draw_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .I(I),
      .done(done), .busy(busy), .err(err),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .draw_en(draw_en), .draw_cls_en(draw_cls_en), .draw_I(draw_I),
      .draw_start_pix(draw_start_pix), .draw_nibbles(draw_nibbles),
      .draw_busy(draw_busy), .draw_col(draw_col)
   );

   // Free-running clock and cycle index.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " control"},
                  int'({done, busy, err, rf_raddr, rf_we, rf_waddr, rf_wdata, draw_en, draw_cls_en}), 0);
      checkOutput({tag, " draw_I"}, int'(draw_I), 0);
      checkOutput({tag, " draw_start_pix"}, int'(draw_start_pix), 0);
      checkOutput({tag, " draw_nibbles"}, int'(draw_nibbles), 0);
   endtask

   // Register file: registered read, VF updated on the write strobe.
   initial begin
      logic [3:0] rdAddr;
      logic       weSeen;
      logic [7:0] wdat;
      for (int r = 0; r < 16; r++) rf[r] = 8'h00;
      forever begin
         @(negedge clk);
         rdAddr = rf_raddr;
         weSeen = rf_we;
         wdat   = rf_wdata;
         @(posedge clk);
         #1;
         rf_rdata = rf[rdAddr];
         if (weSeen) rf[15] = wdat;
      end
   end

   // Draw engine: optional vsync window, then busy for engLen cycles after a request.
   initial begin
      forever begin
         @(negedge clk);
         if (draw_en || draw_cls_en) begin
            engFrom = cyc + 1;
            engTo   = cyc + engLen;
            colAt   = (colOff >= 0) ? cyc + 1 + colOff : -1;
         end
         @(posedge clk);
         #1;
         draw_busy = ((cyc >= vsyncFrom) && (cyc <= vsyncTo)) || ((cyc >= engFrom) && (cyc <= engTo));
         draw_col  = (cyc == colAt);
      end
   end

   task automatic handleEvent(input int kind);
      ev_t e;
      if (expQ.size() == 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL unexpected event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
         e = expQ.pop_front();
         checkOutput("event kind", kind, e.kind);
         checkOutput("event cycle", cyc, e.cyc);
         case (kind)
            0: begin
               checkOutput("draw_I", int'(draw_I), e.a);
               checkOutput("draw_start_pix", int'(draw_start_pix), e.b);
               checkOutput("draw_nibbles", int'(draw_nibbles), e.c);
            end
            2: begin
               checkOutput("rf_waddr", int'(rf_waddr), e.a);
               checkOutput("rf_wdata", int'(rf_wdata), e.b);
            end
            3: begin
               checkOutput("err", int'(err), e.a);
               checkOutput("busy with done", int'(busy), 0);
            end
            default: ;
         endcase
      end
   endtask

   // Monitor: every strobe the DUT presents must match the next expected event.
   initial begin
      forever begin
         @(negedge clk);
         if (draw_en)     handleEvent(0);
         if (draw_cls_en) handleEvent(1);
         if (rf_we)       handleEvent(2);
         if (done)        handleEvent(3);
      end
   end

   task automatic applyStimulus(input logic [15:0] opc, input logic [15:0] iVal,
                                input logic [7:0] vx, input logic [7:0] vy,
                                input int vsync, input int eLen, input int cOff,
                                input bit extraStart, input int abortAt);
      int s, e, w, xv, yv, n, pix;
      bit timedOut;
      rf[opc[11:8]] = vx;
      rf[opc[7:4]]  = vy;
      xv  = int'(rf[opc[11:8]]);
      yv  = int'(rf[opc[7:4]]);
      n   = int'(opc[3:0]);
      pix = (yv % 32) * 64 + (xv % 64);
      @(posedge clk);
      #1;
      s = cyc;
      vsyncFrom = s + 1;
      vsyncTo   = s + vsync;
      engLen    = eLen;
      colOff    = cOff;
      start  = 1'b1;
      opcode = opc;
      I      = iVal;
      if (opc == 16'h00E0) begin
         e = s + 1 + vsync;
         expQ.push_back('{1, e, 0, 0, 0});
         expQ.push_back('{3, e + CLS + 1, 0, 0, 0});
      end else if (opc[15:12] == 4'hD) begin
         if (n == 0) begin
            expQ.push_back('{2, s + 4, 15, 0, 0});
            expQ.push_back('{3, s + 5, 0, 0, 0});
         end else begin
            e = (s + vsync + 1 > s + 4) ? s + vsync + 1 : s + 4;
            w = (e + eLen + 1 > e + 4) ? e + eLen + 1 : e + 4;
            expQ.push_back('{0, e, int'(iVal), pix, n});
            expQ.push_back('{2, w + 1, 15, (cOff >= 0) ? 1 : 0, 0});
            expQ.push_back('{3, w + 2, 0, 0, 0});
         end
      end else begin
         expQ.push_back('{3, s + 1, 1, 0, 0});
      end
      @(negedge clk);
      checkOutput("busy in start cycle", int'(busy), 1);
      @(posedge clk);
      #1;
      start  = 1'b0;
      opcode = 16'($urandom);
      I      = 16'($urandom);
      if (extraStart) begin
         @(posedge clk);
         #1;
         start  = 1'b1;
         opcode = 16'h8123;
         @(posedge clk);
         #1;
         start  = 1'b0;
      end
      if (abortAt > 0) begin
         while (cyc < s + abortAt) begin
            @(posedge clk);
            #1;
         end
         rst = 1'b1;
         expQ.delete();
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         checkAllZero("after abort");
         repeat (60) @(negedge clk);
      end else begin
         timedOut = 1'b1;
         for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done) begin
               timedOut = 1'b0;
               break;
            end
         end
         checkOutput("done within budget", int'(timedOut), 0);
         if (timedOut) expQ.delete();
         if (opc[15:12] == 4'hD && n != 0 && !timedOut) begin
            checkOutput("draw_I held", int'(draw_I), int'(iVal));
            checkOutput("start_pix held", int'(draw_start_pix), pix);
            checkOutput("nibbles held", int'(draw_nibbles), n);
         end
      end
   endtask

   // Directed cases from the opcode rules, then randomized operations.
   initial begin
      logic [15:0] opc;
      int sel, eLen, cOff, vs;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      applyStimulus(16'hD125, 16'h0200, 8'h05, 8'h03, 0, 40, -1, 1'b1, 0);
      applyStimulus(16'hD125, 16'h0300, 8'h47, 8'h25, 0, 10, -1, 1'b0, 0);
      applyStimulus(16'hD125, 16'h0400, 8'h10, 8'h04, 0, 40, 10, 1'b0, 0);
      applyStimulus(16'hD345, 16'h0500, 8'h3F, 8'h1F, 103, 20, -1, 1'b0, 0);
      applyStimulus(16'h00E0, 16'h0000, 8'h00, 8'h00, 0, 30, -1, 1'b1, 0);
      applyStimulus(16'hD120, 16'h0600, 8'h11, 8'h22, 0, 10, -1, 1'b0, 0);
      applyStimulus(16'h8123, 16'h0700, 8'h00, 8'h00, 0, 10, -1, 1'b0, 0);
      applyStimulus(16'hD125, 16'h0800, 8'h05, 8'h03, 0, 40, 5, 1'b0, 15);
      applyStimulus(16'hD125, 16'h0900, 8'h06, 8'h07, 0, 12, -1, 1'b0, 0);

      for (int t = 0; t < 24; t++) begin
         sel  = int'($urandom_range(0, 9));
         eLen = int'($urandom_range(1, 30));
         cOff = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, eLen - 1));
         vs   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
         if (sel == 0) begin
            opc = 16'h00E0;
         end else if (sel == 1) begin
            opc = 16'($urandom);
            if (opc[15:12] == 4'hD) opc[15:12] = 4'h8;
            if (opc == 16'h00E0) opc = 16'h00E1;
         end else begin
            opc = {4'hD, 4'($urandom), 4'($urandom), 4'($urandom)};
            if ($urandom_range(0, 4) == 0) opc[3:0] = 4'h0;
         end
         applyStimulus(opc, 16'($urandom), 8'($urandom), 8'($urandom), vs, eLen, cOff,
                       ($urandom_range(0, 1) == 1) && (sel != 1), 0);
      end

      repeat (5) @(negedge clk);
      checkOutput("pending events", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
